// File: rtl/mem_stage_pkg.sv
// Shared types and codes for the memory-access pipeline stage.
// Holds the FSM state enum, access size codes and writeback-select codes.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } mem_state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] WSEL_ALU  = 2'b00;
   localparam logic [1:0] WSEL_LOAD = 2'b01;
   localparam logic [1:0] WSEL_WD   = 2'b10;

   // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      return ((size == SIZE_HALF) && offset[0]) ||
             ((size == SIZE_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// and load data extraction with sign or zero extension.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  st_offset,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [1:0]  ld_offset,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;
   logic        ld_sign;

   // Narrow stores replicate the value across every lane so the enable alone picks the lane.
   always_comb begin
      be    = 4'b1111;
      wdata = st_data;
      case (st_size)
         SIZE_BYTE: begin
            be    = 4'b0001 << st_offset;
            wdata = {4{st_data[7:0]}};
         end
         SIZE_HALF: begin
            be    = 4'b0011 << st_offset;
            wdata = {2{st_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = st_data;
         end
      endcase
   end

   always_comb begin
      shifted = rdata >> {ld_offset, 3'b000};
      ld_sign = 1'b0;
      ld_data = rdata;
      case (ld_size)
         SIZE_BYTE: begin
            ld_sign = ~ld_unsigned & shifted[7];
            ld_data = {{24{ld_sign}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            ld_sign = ~ld_unsigned & shifted[15];
            ld_data = {{16{ld_sign}}, shifted[15:0]};
         end
         default: begin
            ld_sign = 1'b0;
            ld_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: passes ALU results straight through and runs loads/stores
// over a req/gnt/rvalid bus, stalling upstream until the access completes or times out.
module mem_access_unit
   import mem_stage_pkg::*;
#(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [31:0] in_wD,
   input  logic [4:0]  in_wR,
   input  logic [1:0]  in_rf_wsel,
   input  logic        in_rf_we,
   input  logic        in_ram_we,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   output logic        stall_o,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_pc,
   output logic [4:0]  wb_wR,
   output logic        wb_rf_we,
   output logic [31:0] wb_data,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int TW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(BUS_TIMEOUT - 1);

   mem_state_t    state;
   mem_state_t    next_state;
   logic [TW-1:0] tmr;
   logic          mem_op;
   logic          misaligned;
   logic          timed_out;
   logic          abort;
   logic          start_req;

   logic [31:0]   lat_addr;
   logic [31:0]   lat_pc;
   logic [4:0]    lat_wR;
   logic [1:0]    lat_size;
   logic          lat_unsigned;
   logic          lat_we;
   logic          lat_rf_we;

   logic [3:0]    al_be;
   logic [31:0]   al_wdata;
   logic [31:0]   al_ld_data;

   assign mem_op     = in_valid & (in_ram_we | (in_rf_wsel == WSEL_LOAD));
   assign misaligned = is_misaligned(in_size, in_addr[1:0]);
   assign timed_out  = (tmr >= TMR_LAST);
   assign start_req  = (state == ST_IDLE) & mem_op & ~misaligned;

   // Gated by rst_n so the stall drops the moment reset asserts, even while in_* still request an access.
   assign stall_o = rst_n & (start_req | (state == ST_REQ) | (state == ST_WAIT));

   mem_align u_align (
      .st_offset   (in_addr[1:0]),
      .st_size     (in_size),
      .st_data     (in_wdata),
      .be          (al_be),
      .wdata       (al_wdata),
      .ld_offset   (lat_addr[1:0]),
      .ld_size     (lat_size),
      .ld_unsigned (lat_unsigned),
      .rdata       (bus_rdata),
      .ld_data     (al_ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A grant or read response wins over an expiring timer in the same cycle.
   always_comb begin
      next_state = state;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_req) begin
               next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_gnt) begin
               next_state = lat_we ? ST_DONE : ST_WAIT;
            end else if (timed_out) begin
               next_state = ST_DONE;
               abort      = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus_rvalid) begin
               next_state = ST_DONE;
            end else if (timed_out) begin
               next_state = ST_DONE;
               abort      = 1'b1;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Counts every cycle spent in REQ and WAIT together; it holds once the limit is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (start_req) begin
         tmr <= '0;
      end else if (((state == ST_REQ) || (state == ST_WAIT)) && !timed_out) begin
         tmr <= tmr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_addr     <= '0;
         lat_pc       <= '0;
         lat_wR       <= '0;
         lat_size     <= '0;
         lat_unsigned <= 1'b0;
         lat_we       <= 1'b0;
         lat_rf_we    <= 1'b0;
      end else if (start_req) begin
         lat_addr     <= in_addr;
         lat_pc       <= in_pc;
         lat_wR       <= in_wR;
         lat_size     <= in_size;
         lat_unsigned <= in_unsigned;
         lat_we       <= in_ram_we;
         lat_rf_we    <= in_rf_we;
      end
   end

   // Bus fields are captured on entry to REQ and held steady until the next access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_be     <= '0;
         bus_wdata  <= '0;
         wb_valid   <= 1'b0;
         wb_pc      <= '0;
         wb_wR      <= '0;
         wb_rf_we   <= 1'b0;
         wb_data    <= '0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
      end else begin
         wb_valid   <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         bus_req    <= (next_state == ST_REQ);
         bus_we     <= (next_state == ST_REQ) ? (start_req ? in_ram_we : lat_we) : 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  bus_addr  <= {in_addr[31:2], 2'b00};
                  bus_be    <= al_be;
                  bus_wdata <= al_wdata;
               end else begin
                  wb_valid <= in_valid;
                  wb_pc    <= in_pc;
                  wb_wR    <= in_wR;
                  if (mem_op) begin
                     wb_rf_we   <= 1'b0;
                     wb_data    <= '0;
                     misalign_o <= 1'b1;
                  end else begin
                     wb_rf_we <= in_valid & in_rf_we;
                     wb_data  <= (in_rf_wsel == WSEL_WD) ? in_wD : in_addr;
                  end
               end
            end
            ST_REQ, ST_WAIT: begin
               if (next_state == ST_DONE) begin
                  wb_valid <= 1'b1;
                  wb_pc    <= lat_pc;
                  wb_wR    <= lat_wR;
                  if (abort) begin
                     wb_rf_we  <= 1'b0;
                     wb_data   <= '0;
                     bus_err_o <= 1'b1;
                  end else begin
                     wb_rf_we <= lat_rf_we;
                     wb_data  <= lat_we ? lat_addr : al_ld_data;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a small bus responder plus an arithmetic
// reference model; a per-cycle compare process scores every writeback slot.
module tb_mem_access_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0, in_addr = '0, in_wdata = '0, in_wD = '0;
   logic [4:0]  in_wR = '0;
   logic [1:0]  in_rf_wsel = '0, in_size = '0;
   logic        in_rf_we = 1'b0, in_ram_we = 1'b0, in_unsigned = 1'b0;
   logic        stall_o, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        wb_valid, wb_rf_we, misalign_o, bus_err_o;
   logic [31:0] wb_pc, wb_data;
   logic [4:0]  wb_wR;

   always #5 clk = ~clk;

   mem_access_unit #(.BUS_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_pc(in_pc), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_wD(in_wD), .in_wR(in_wR), .in_rf_wsel(in_rf_wsel), .in_rf_we(in_rf_we),
      .in_ram_we(in_ram_we), .in_size(in_size), .in_unsigned(in_unsigned),
      .stall_o(stall_o), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wR(wb_wR),
      .wb_rf_we(wb_rf_we), .wb_data(wb_data), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   typedef struct {
      logic [31:0] pc, addr, wdata, wD, rdata;
      logic [4:0]  wR;
      logic [1:0]  wsel, size;
      logic        rf_we, ram_we, uns, spur_rv;
      int          gnt_dly, rv_dly;
      logic        has_lit, has_bus_lit;
      logic [31:0] lit_data, lit_addr, lit_wdata;
      logic [3:0]  lit_be;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] pc, data, lit;
      logic [4:0]  wR;
      logic        rf_we, chk_data, mis, err, has_lit;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   logic cmp_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
      longint unsigned v;
      longint unsigned span;
      v = rdata;
      if (nbytes(size) == 4) return rdata;
      v = v / (64'd1 << (8 * (addr % 4)));
      span = 64'd1 << (8 * nbytes(size));
      v = v % span;
      if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
      int n;
      int m;
      n = nbytes(size);
      m = ((1 << n) - 1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] size);
      if (nbytes(size) == 1) return (d % 256) * 32'h0101_0101;
      if (nbytes(size) == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic vec_t blank();
      vec_t v;
      v = '{pc: 0, addr: 0, wdata: 0, wD: 0, rdata: 0, wR: 0, wsel: 0, size: 2'b10,
            rf_we: 0, ram_we: 0, uns: 0, spur_rv: 0, gnt_dly: 1, rv_dly: 1,
            has_lit: 0, has_bus_lit: 0, lit_data: 0, lit_addr: 0, lit_wdata: 0, lit_be: 0};
      return v;
   endfunction

   // Present one instruction, play the bus slave, and score stall/bus behaviour.
   task automatic applyStimulus(input vec_t v, input string name);
      logic mem, ld, mis, no_gnt, tout;
      int   exp_stall, exp_req, stall_n, req_n, wait_n, guard;
      logic granted;
      exp_t e;
      stall_n = 0; req_n = 0; wait_n = 0; guard = 0; granted = 1'b0;
      mem    = v.ram_we || (v.wsel == 2'b01);
      ld     = mem && !v.ram_we;
      mis    = mem && ((v.addr % nbytes(v.size)) != 0);
      no_gnt = (v.gnt_dly == 0) || (v.gnt_dly > T);
      tout   = mem && !mis && (no_gnt || (ld && ((v.rv_dly == 0) || (v.gnt_dly + v.rv_dly > T))));
      exp_req   = (!mem || mis) ? 0 : (no_gnt ? T : v.gnt_dly);
      exp_stall = (!mem || mis) ? 0 : (tout ? T + 1 : 1 + v.gnt_dly + (ld ? v.rv_dly : 0));

      e.pc = v.pc; e.wR = v.wR; e.mis = mis; e.err = tout; e.has_lit = v.has_lit; e.lit = v.lit_data;
      e.lit = v.lit_data; e.data = 0; e.chk_data = 1'b1; e.rf_we = v.rf_we;
      if (!mem) e.data = (v.wsel == 2'b10) ? v.wD : v.addr;
      else if (mis) begin e.rf_we = 1'b0; e.chk_data = 1'b0; end
      else if (tout) e.rf_we = 1'b0;
      else if (ld) e.data = model_load(v.rdata, v.addr, v.size, v.uns);
      else e.chk_data = 1'b0;

      in_valid = 1'b1; in_pc = v.pc; in_addr = v.addr; in_wdata = v.wdata; in_wD = v.wD;
      in_wR = v.wR; in_rf_wsel = v.wsel; in_rf_we = v.rf_we; in_ram_we = v.ram_we;
      in_size = v.size; in_unsigned = v.uns;

      forever begin
         @(negedge clk);
         if (bus_req) begin
            req_n++;
            checkOutput({name, ".bus_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
            checkOutput({name, ".bus_we"}, bus_we, v.ram_we);
            if (v.ram_we) begin
               checkOutput({name, ".bus_be"}, bus_be, model_be(v.addr, v.size));
               checkOutput({name, ".bus_wdata"}, bus_wdata, model_wdata(v.wdata, v.size));
            end
            if (v.has_bus_lit && req_n == 1) begin
               checkOutput({name, ".lit_addr"}, bus_addr, v.lit_addr);
               checkOutput({name, ".lit_be"}, bus_be, v.lit_be);
               checkOutput({name, ".lit_wdata"}, bus_wdata, v.lit_wdata);
            end
         end
         if (!stall_o) break;
         stall_n++;
         bus_gnt = bus_req && (req_n == v.gnt_dly);
         bus_rvalid = 1'b0;
         if (bus_gnt) begin
            granted = 1'b1;
            if (v.spur_rv) begin bus_rvalid = 1'b1; bus_rdata = ~v.rdata; end
         end else if (granted && !bus_req) begin
            wait_n++;
            if (wait_n == v.rv_dly) begin bus_rvalid = 1'b1; bus_rdata = v.rdata; end
         end
         guard++;
         if (guard > 40) begin
            n_checks++;
            $display("[TB] FAIL %s.stall_bound: stall_o still high after %0d cycles, expected release", name, guard);
            break;
         end
      end
      e.due = (mem && !mis) ? cyc : cyc + 1;
      exp_q.push_back(e);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      checkOutput({name, ".stall_cycles"}, stall_n, exp_stall);
      checkOutput({name, ".req_cycles"}, req_n, exp_req);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Writeback slot check on every cycle out of reset.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (cmp_en && rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               checkOutput("wb_valid", wb_valid, 1);
               checkOutput("wb_pc", wb_pc, e.pc);
               checkOutput("wb_wR", wb_wR, e.wR);
               checkOutput("wb_rf_we", wb_rf_we, e.rf_we);
               if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
               if (e.has_lit) checkOutput("wb_data_lit", wb_data, e.lit);
               checkOutput("misalign_o", misalign_o, e.mis);
               checkOutput("bus_err_o", bus_err_o, e.err);
            end else begin
               checkOutput("wb_valid_idle", wb_valid, 0);
               checkOutput("misalign_idle", misalign_o, 0);
               checkOutput("bus_err_idle", bus_err_o, 0);
            end
         end
      end
   end

   task automatic resetDuringWait();
      in_valid = 1'b1; in_pc = 32'h0000_0500; in_addr = 32'h0000_4000; in_wR = 5'd9;
      in_rf_wsel = 2'b01; in_rf_we = 1'b1; in_ram_we = 1'b0; in_size = 2'b10; in_unsigned = 1'b0;
      @(negedge clk);
      checkOutput("rst.idle_stall", stall_o, 1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst.req", bus_req, 1);
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      @(negedge clk);
      checkOutput("rst.wait_req", bus_req, 0);
      checkOutput("rst.wait_stall", stall_o, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst.bus_req", bus_req, 0);
      checkOutput("rst.stall_o", stall_o, 0);
      checkOutput("rst.wb_valid", wb_valid, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      in_valid = 1'b1; in_rf_wsel = 2'b01; in_addr = 32'h0000_0100; in_size = 2'b10;
      #12;
      checkOutput("reset.stall_o", stall_o, 0);
      checkOutput("reset.bus_req", bus_req, 0);
      checkOutput("reset.wb_valid", wb_valid, 0);
      checkOutput("reset.bus_be", bus_be, 0);
      checkOutput("reset.wb_data", wb_data, 0);
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      cmp_en = 1'b1;

      v = blank(); v.pc = 32'h100; v.addr = 32'h10; v.wsel = 2'b00; v.rf_we = 1; v.wR = 5'd3;
      v.has_lit = 1; v.lit_data = 32'h10;
      applyStimulus(v, "alu");
      v = blank(); v.pc = 32'h104; v.addr = 32'h55; v.wD = 32'hDEAD_BEEF; v.wsel = 2'b10; v.rf_we = 1; v.wR = 5'd7;
      v.has_lit = 1; v.lit_data = 32'hDEAD_BEEF;
      applyStimulus(v, "wd_sel");
      v = blank(); v.pc = 32'h108; v.addr = 32'h1003; v.wdata = 32'hAB; v.ram_we = 1; v.size = 2'b00; v.gnt_dly = 3;
      v.has_bus_lit = 1; v.lit_addr = 32'h1000; v.lit_be = 4'b1000; v.lit_wdata = 32'hABAB_ABAB;
      applyStimulus(v, "sb");
      v = blank(); v.pc = 32'h10C; v.addr = 32'h1402; v.wdata = 32'h1234_CAFE; v.ram_we = 1; v.size = 2'b01;
      v.has_bus_lit = 1; v.lit_addr = 32'h1400; v.lit_be = 4'b1100; v.lit_wdata = 32'hCAFE_CAFE;
      applyStimulus(v, "sh");
      v = blank(); v.pc = 32'h110; v.addr = 32'h1500; v.wdata = 32'h0123_4567; v.ram_we = 1; v.gnt_dly = 2;
      applyStimulus(v, "sw");
      v = blank(); v.pc = 32'h114; v.addr = 32'h2002; v.wsel = 2'b01; v.rf_we = 1; v.wR = 5'd10; v.size = 2'b01;
      v.rdata = 32'h8001_1234; v.rv_dly = 2; v.has_lit = 1; v.lit_data = 32'hFFFF_8001;
      applyStimulus(v, "lh");
      v.pc = 32'h118; v.uns = 1; v.spur_rv = 1; v.lit_data = 32'h0000_8001;
      applyStimulus(v, "lhu");
      v = blank(); v.pc = 32'h11C; v.addr = 32'h2001; v.wsel = 2'b01; v.rf_we = 1; v.wR = 5'd11; v.size = 2'b00;
      v.rdata = 32'h0000_8000; v.gnt_dly = 2; v.has_lit = 1; v.lit_data = 32'hFFFF_FF80;
      applyStimulus(v, "lb");
      v = blank(); v.pc = 32'h120; v.addr = 32'h2003; v.wsel = 2'b01; v.rf_we = 1; v.wR = 5'd12; v.size = 2'b00;
      v.uns = 1; v.rdata = 32'hC300_0000; v.has_lit = 1; v.lit_data = 32'h0000_00C3;
      applyStimulus(v, "lbu");
      v = blank(); v.pc = 32'h124; v.addr = 32'h2004; v.wsel = 2'b01; v.rf_we = 1; v.wR = 5'd13;
      v.rdata = 32'h89AB_CDEF; v.has_lit = 1; v.lit_data = 32'h89AB_CDEF;
      applyStimulus(v, "lw");
      v = blank(); v.pc = 32'h128; v.addr = 32'h3001; v.wsel = 2'b01; v.rf_we = 1; v.wR = 5'd14;
      applyStimulus(v, "lw_mis");
      v = blank(); v.pc = 32'h12C; v.addr = 32'h3003; v.wdata = 32'h55; v.ram_we = 1; v.size = 2'b01;
      applyStimulus(v, "sh_mis");
      v = blank(); v.pc = 32'h130; v.addr = 32'h3100; v.wdata = 32'h77; v.ram_we = 1; v.gnt_dly = 0; v.rf_we = 1;
      v.has_lit = 1; v.lit_data = 32'h0;
      applyStimulus(v, "sw_timeout");
      v = blank(); v.pc = 32'h134; v.addr = 32'h3200; v.wsel = 2'b01; v.rf_we = 1; v.wR = 5'd15; v.rv_dly = 0;
      v.rdata = 32'h1111_2222;
      applyStimulus(v, "lw_timeout");
      resetDuringWait();
      v = blank(); v.pc = 32'h200; v.addr = 32'h42; v.rf_we = 1; v.wR = 5'd1;
      applyStimulus(v, "alu_after_reset");
      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
